// File: rtl/acl_txarq_sched_if.sv
// Signal bundle between the TX buffer / RX ARQ logic and the ACL TX ARQ scheduler.
// The scheduler connects through the master modport; the surrounding datapath uses slave.
interface acl_txarq_sched_if #(
  parameter int CNT_W = 4
);
  logic             conn_new;
  logic             regi_isMaster;
  logic             tx_slot_p;
  logic             ack_valid_p;
  logic             rx_ARQN;
  logic             rxFLOW;
  logic             buf_valid;
  logic [3:0]       buf_pktype;
  logic [9:0]       buf_len;
  logic             flushcmd;
  logic             tx_go_p;
  logic [3:0]       tx_pktype;
  logic [9:0]       tx_len;
  logic             txSEQN;
  logic             sel_new;
  logic             sel_old;
  logic             sel_zero;
  logic             buf_pop;
  logic [CNT_W-1:0] retx_cnt;
  logic             arq_pending;

  modport master (
    input  conn_new, regi_isMaster, tx_slot_p, ack_valid_p, rx_ARQN, rxFLOW,
           buf_valid, buf_pktype, buf_len, flushcmd,
    output tx_go_p, tx_pktype, tx_len, txSEQN, sel_new, sel_old, sel_zero,
           buf_pop, retx_cnt, arq_pending
  );

  modport slave (
    output conn_new, regi_isMaster, tx_slot_p, ack_valid_p, rx_ARQN, rxFLOW,
           buf_valid, buf_pktype, buf_len, flushcmd,
    input  tx_go_p, tx_pktype, tx_len, txSEQN, sel_new, sel_old, sel_zero,
           buf_pop, retx_cnt, arq_pending
  );
endinterface

// File: rtl/acl_txarq_sched.sv
// Per-slot ACL TX ARQ scheduler: picks new/retransmit/zero-length/NULL-POLL and owns txSEQN.
// Optional macro AUTOFLUSH_EN: flush a payload automatically after MAX_RETX retransmissions.
module acl_txarq_sched #(
  parameter int MAX_RETX = 7,
  parameter int CNT_W    = 4
) (
  input  logic              clk_6M,
  input  logic              rst,
  acl_txarq_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

  localparam logic [3:0] PKT_NULL = 4'h0;
  localparam logic [3:0] PKT_POLL = 4'h1;
  localparam logic [3:0] PKT_DM1  = 4'h3;

  state_t           state, state_nxt, ack_state;
  logic             seqn, seqn_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       lat_pktype, lat_pktype_nxt, pktype, pktype_nxt;
  logic [9:0]       lat_len, lat_len_nxt, len, len_nxt;
  logic             go, go_nxt, pop, pop_nxt;
  logic             sel_new, sel_new_nxt, sel_old, sel_old_nxt, sel_zero, sel_zero_nxt;
  logic             flush_req;

  always_ff @(posedge clk_6M or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seqn       <= 1'b1;
      cnt        <= '0;
      lat_pktype <= '0;
      lat_len    <= '0;
      pktype     <= '0;
      len        <= '0;
      go         <= 1'b0;
      pop        <= 1'b0;
      sel_new    <= 1'b0;
      sel_old    <= 1'b0;
      sel_zero   <= 1'b0;
    end else if (bus.conn_new) begin
      state      <= IDLE;
      seqn       <= 1'b1;
      cnt        <= '0;
      lat_pktype <= '0;
      lat_len    <= '0;
      pktype     <= '0;
      len        <= '0;
      go         <= 1'b0;
      pop        <= 1'b0;
      sel_new    <= 1'b0;
      sel_old    <= 1'b0;
      sel_zero   <= 1'b0;
    end else begin
      state      <= state_nxt;
      seqn       <= seqn_nxt;
      cnt        <= cnt_nxt;
      lat_pktype <= lat_pktype_nxt;
      lat_len    <= lat_len_nxt;
      pktype     <= pktype_nxt;
      len        <= len_nxt;
      go         <= go_nxt;
      pop        <= pop_nxt;
      sel_new    <= sel_new_nxt;
      sel_old    <= sel_old_nxt;
      sel_zero   <= sel_zero_nxt;
    end
  end

  // The ACK is applied first so a coinciding slot decides on the post-ACK state.
  always_comb begin
    ack_state      = state;
    state_nxt      = state;
    seqn_nxt       = seqn;
    cnt_nxt        = cnt;
    lat_pktype_nxt = lat_pktype;
    lat_len_nxt    = lat_len;
    pktype_nxt     = pktype;
    len_nxt        = len;
    go_nxt         = 1'b0;
    pop_nxt        = 1'b0;
    sel_new_nxt    = sel_new;
    sel_old_nxt    = sel_old;
    sel_zero_nxt   = sel_zero;
`ifdef AUTOFLUSH_EN
    flush_req      = bus.flushcmd || (cnt == CNT_W'(MAX_RETX));
`else
    flush_req      = bus.flushcmd;
`endif

    if (bus.ack_valid_p && bus.rx_ARQN) begin
      if (state == PEND) begin
        pop_nxt   = 1'b1;
        seqn_nxt  = ~seqn;
        cnt_nxt   = '0;
        ack_state = IDLE;
      end else if (state == FLUSH) begin
        seqn_nxt  = ~seqn;
        ack_state = IDLE;
      end
    end
    state_nxt = ack_state;

    if (bus.tx_slot_p) begin
      go_nxt       = 1'b1;
      sel_new_nxt  = 1'b0;
      sel_old_nxt  = 1'b0;
      sel_zero_nxt = 1'b0;
      pktype_nxt   = bus.regi_isMaster ? PKT_POLL : PKT_NULL;
      len_nxt      = '0;
      case (ack_state)
        IDLE: begin
          if (bus.buf_valid && bus.rxFLOW) begin
            sel_new_nxt    = 1'b1;
            pktype_nxt     = bus.buf_pktype;
            len_nxt        = bus.buf_len;
            lat_pktype_nxt = bus.buf_pktype;
            lat_len_nxt    = bus.buf_len;
            state_nxt      = PEND;
          end
        end
        PEND: begin
          if (flush_req) begin
            sel_zero_nxt = 1'b1;
            pktype_nxt   = PKT_DM1;
            pop_nxt      = 1'b1;
            cnt_nxt      = '0;
            state_nxt    = FLUSH;
          end else if (bus.rxFLOW) begin
            sel_old_nxt = 1'b1;
            pktype_nxt  = lat_pktype;
            len_nxt     = lat_len;
            if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + 1'b1;
          end
        end
        FLUSH: begin
          sel_zero_nxt = 1'b1;
          pktype_nxt   = PKT_DM1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.tx_go_p     = go;
  assign bus.tx_pktype   = pktype;
  assign bus.tx_len      = len;
  assign bus.txSEQN      = seqn;
  assign bus.sel_new     = sel_new;
  assign bus.sel_old     = sel_old;
  assign bus.sel_zero    = sel_zero;
  assign bus.buf_pop     = pop;
  assign bus.retx_cnt    = cnt;
  assign bus.arq_pending = (state != IDLE);

endmodule

// File: tb/tb_acl_txarq_sched.sv
// Scoreboard bench for acl_txarq_sched: a transaction-level model queues expected decisions
// and buffer pops; a negedge monitor compares them as the DUT presents tx_go_p / buf_pop.
module tb_acl_txarq_sched;
  localparam int MAX_RETX = 2;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic clk_6M = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_6M = ~clk_6M;

  acl_txarq_sched_if #(.CNT_W(CNT_W)) bus ();

  acl_txarq_sched #(.MAX_RETX(MAX_RETX), .CNT_W(CNT_W)) dut (
    .clk_6M (clk_6M),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] pt;
    logic [9:0] ln;
    logic       seqn;
    logic [2:0] sel;
    int         retx;
    logic       pend;
  } exp_tx_t;

  exp_tx_t expTx[$];
  int      expPop[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc    = 0;

  // Model: what is outstanding (0 none, 1 data, 2 zero-length), SEQN, retries, latched payload.
  int         mKind = 0;
  bit         mSeqn = 1'b1;
  int         mRetx = 0;
  logic [3:0] mPt   = '0;
  logic [9:0] mLn   = '0;

  always @(posedge clk_6M) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic modelStep(input bit slot, input bit ack, input bit arqn, input bit flow,
                           input bit bv, input logic [3:0] pt, input logic [9:0] ln,
                           input bit flush, input bit master, input bit cn);
    exp_tx_t e;
    bit      flushNow;
    if (cn) begin
      mKind = 0; mSeqn = 1'b1; mRetx = 0;
      return;
    end
    if (ack && arqn && mKind == 1) begin
      expPop.push_back(cyc + 1);
      mSeqn = !mSeqn; mRetx = 0; mKind = 0;
    end else if (ack && arqn && mKind == 2) begin
      mSeqn = !mSeqn; mKind = 0;
    end
    if (slot) begin
      e.cyc = cyc + 1;
      e.sel = 3'b000;
      e.pt  = master ? 4'h1 : 4'h0;
      e.ln  = '0;
      flushNow = flush;
`ifdef AUTOFLUSH_EN
      if (mRetx == MAX_RETX) flushNow = 1'b1;
`endif
      if (mKind == 0) begin
        if (bv && flow) begin
          e.sel = 3'b100; e.pt = pt; e.ln = ln;
          mPt = pt; mLn = ln; mKind = 1;
        end
      end else if (mKind == 1) begin
        if (flushNow) begin
          e.sel = 3'b001; e.pt = 4'h3;
          expPop.push_back(cyc + 1);
          mRetx = 0; mKind = 2;
        end else if (flow) begin
          e.sel = 3'b010; e.pt = mPt; e.ln = mLn;
          mRetx = (mRetx < SAT) ? mRetx + 1 : SAT;
        end
      end else begin
        e.sel = 3'b001; e.pt = 4'h3;
      end
      e.seqn = mSeqn;
      e.retx = mRetx;
      e.pend = (mKind != 0);
      expTx.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit slot, input bit ack, input bit arqn, input bit flow,
                               input bit bv, input logic [3:0] pt, input logic [9:0] ln,
                               input bit flush, input bit master, input bit cn);
    @(posedge clk_6M);
    #1;
    bus.tx_slot_p     = slot;
    bus.ack_valid_p   = ack;
    bus.rx_ARQN       = arqn;
    bus.rxFLOW        = flow;
    bus.buf_valid     = bv;
    bus.buf_pktype    = pt;
    bus.buf_len       = ln;
    bus.flushcmd      = flush;
    bus.regi_isMaster = master;
    bus.conn_new      = cn;
    modelStep(slot, ack, arqn, flow, bv, pt, ln, flush, master, cn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0, 4'h0, 10'd0, 0, 0, 0);
  endtask

  // Monitor: expectations are stamped with the cycle the DUT must present them in.
  exp_tx_t e;
  int      p;
  always @(negedge clk_6M) begin
    if (!rst) begin
      while (expTx.size() > 0 && expTx[0].cyc < cyc) begin
        e = expTx.pop_front();
        checkOutput("tx_go_missing", 0, 1);
      end
      if (bus.tx_go_p) begin
        if (expTx.size() > 0 && expTx[0].cyc == cyc) begin
          e = expTx.pop_front();
          checkOutput("tx_pktype", int'(bus.tx_pktype), int'(e.pt));
          checkOutput("tx_len", int'(bus.tx_len), int'(e.ln));
          checkOutput("txSEQN", int'(bus.txSEQN), int'(e.seqn));
          checkOutput("sel_new_old_zero", int'({bus.sel_new, bus.sel_old, bus.sel_zero}),
                      int'(e.sel));
          checkOutput("retx_cnt", int'(bus.retx_cnt), e.retx);
          checkOutput("arq_pending", int'(bus.arq_pending), int'(e.pend));
        end else begin
          checkOutput("tx_go_unexpected", 1, 0);
        end
      end
      while (expPop.size() > 0 && expPop[0] < cyc) begin
        p = expPop.pop_front();
        checkOutput("buf_pop_missing", 0, 1);
      end
      if (bus.buf_pop) begin
        if (expPop.size() > 0 && expPop[0] == cyc) begin
          p = expPop.pop_front();
          checkOutput("buf_pop", 1, 1 + int'(p != cyc));
        end else begin
          checkOutput("buf_pop_unexpected", 1, 0);
        end
      end
    end
  end

  initial begin
    bus.tx_slot_p = 0; bus.ack_valid_p = 0; bus.rx_ARQN = 0; bus.rxFLOW = 0;
    bus.buf_valid = 0; bus.buf_pktype = '0; bus.buf_len = '0; bus.flushcmd = 0;
    bus.regi_isMaster = 0; bus.conn_new = 0;
    repeat (3) @(posedge clk_6M);
    @(negedge clk_6M);
    checkOutput("reset_txSEQN", int'(bus.txSEQN), 1);
    checkOutput("reset_tx_go_p", int'(bus.tx_go_p), 0);
    checkOutput("reset_sel", int'({bus.sel_new, bus.sel_old, bus.sel_zero}), 0);
    checkOutput("reset_retx_cnt", int'(bus.retx_cnt), 0);
    checkOutput("reset_arq_pending", int'(bus.arq_pending), 0);
    checkOutput("reset_buf_pop", int'(bus.buf_pop), 0);
    @(posedge clk_6M);
    #1 rst = 1'b0;

    // New payload, then ACK
    applyStimulus(1, 0, 0, 1, 1, 4'h4, 10'd27, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'h0, 10'd0, 0, 0, 0);
    idle(1);
    @(negedge clk_6M);
    checkOutput("after_ack_txSEQN", int'(bus.txSEQN), 0);
    checkOutput("after_ack_arq_pending", int'(bus.arq_pending), 0);

    // NAK then three retransmission slots, buffer content changing underneath
    applyStimulus(1, 0, 0, 1, 1, 4'h5, 10'd100, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 1, 4'h9, 10'd7, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 1, 4'hA, 10'd3, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'h0, 10'd0, 0, 1, 0);

    // Host flush of the outstanding payload, zero-length resend, then ACK
    applyStimulus(1, 0, 0, 1, 1, 4'h4, 10'd17, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 4'h4, 10'd17, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 1, 4'h4, 10'd17, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'h0, 10'd0, 0, 0, 0);

    // ACK coinciding with slot while the next payload is queued
    applyStimulus(1, 0, 0, 1, 1, 4'hB, 10'd200, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 4'hE, 10'd339, 0, 0, 0);

    // STOP flow holds the payload; flushcmd in IDLE is ignored
    applyStimulus(1, 0, 0, 0, 1, 4'h0, 10'd0, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'h0, 10'd0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0, 4'h0, 10'd0, 1, 0, 0);

    // conn_new clears everything without a pop
    applyStimulus(1, 0, 0, 1, 1, 4'h8, 10'd50, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 4'h0, 10'd0, 0, 0, 1);
    idle(1);
    @(negedge clk_6M);
    checkOutput("conn_new_txSEQN", int'(bus.txSEQN), 1);
    checkOutput("conn_new_sel", int'({bus.sel_new, bus.sel_old, bus.sel_zero}), 0);
    checkOutput("conn_new_arq_pending", int'(bus.arq_pending), 0);
    checkOutput("conn_new_tx_len", int'(bus.tx_len), 0);

    // Long NAK run: saturation without autoflush, autoflush at MAX_RETX with it
    applyStimulus(1, 0, 0, 1, 1, 4'hF, 10'd1023, 0, 0, 0);
    for (int i = 0; i < 18; i++) applyStimulus(1, 1, 0, 1, 1, 4'h2, 10'd9, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 4'h0, 10'd0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(2) == 0), ($urandom_range(3) == 0), $urandom_range(1) == 1,
                    ($urandom_range(7) != 0), ($urandom_range(3) != 0),
                    4'($urandom_range(15)), 10'($urandom_range(1023)),
                    ($urandom_range(15) == 0), $urandom_range(1) == 1,
                    ($urandom_range(199) == 0));
    end
    idle(4);
    @(negedge clk_6M);
    checkOutput("tx_queue_drained", expTx.size(), 0);
    checkOutput("pop_queue_drained", expPop.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
